icache_sa: RTL and testbench

- Parametrised set-associative instruction cache between the IFU fetch request (inst_require/pc) and the AXI4 read-only burst port to memory.
- Successor to the direct-mapped single-way cache. Adds configurable ways, sets and line length; per-set round-robin replacement; fence.i flush; bus-error reporting; and hardware hit/miss counters.
- The hardware counters replace simulator-side statistics hooks.

---
 rtl/icache_sa_if.sv | 35 +++
 rtl/icache_sa.sv | 224 ++++++++++++++++++++++
 tb/tb_icache_sa.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/icache_sa_if.sv
// Fetch-side and AXI4 read-channel bundle for the set-associative instruction cache.
// The master modport is the cache; the slave modport is the IFU/memory side.
interface icache_sa_if;
    logic        inst_require;
    logic [31:0] pc;
    logic        flush;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_fault;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    modport master (
        input  inst_require, pc, flush, arready, rvalid, rdata, rresp, rlast,
        output inst_valid, inst, inst_fault, arvalid, araddr, arlen, arsize, arburst,
               rready, hit_cnt, miss_cnt
    );

    modport slave (
        output inst_require, pc, flush, arready, rvalid, rdata, rresp, rlast,
        input  inst_valid, inst, inst_fault, arvalid, araddr, arlen, arsize, arburst,
               rready, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/icache_sa.sv
// Set-associative instruction cache with round-robin replacement, fence.i flush,
// AXI4 burst refill with error reporting, and hit/miss counters.
module icache_sa #(
    parameter int WAYS       = 2,
    parameter int SETS       = 8,
    parameter int LINE_WORDS = 4
) (
    input logic         clock,
    input logic         reset,
    icache_sa_if.master bus
);
    localparam int OB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(SETS);
    localparam int TW = 32 - OB - 2 - IB;
    localparam int WB = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, AR, FILL, RESP} state_t;

    state_t          state_q, state_d;
    logic [WB-1:0]   victim_q, victim_d;
    logic            set_full_q, set_full_d;
    logic [OB-1:0]   beat_q, beat_d;
    logic            err_q, err_d;
    logic            pend_flush_q, pend_flush_d;
    logic [31:0]     inst_q, inst_d;
    logic            inst_valid_q, inst_valid_d;
    logic            inst_fault_q, inst_fault_d;
    logic            arvalid_q, arvalid_d;
    logic [31:0]     hit_cnt_q, hit_cnt_d;
    logic [31:0]     miss_cnt_q, miss_cnt_d;

    logic [31:0]     data_q  [WAYS][SETS][LINE_WORDS];
    logic [31:0]     data_d  [WAYS][SETS][LINE_WORDS];
    logic [TW-1:0]   tag_q   [WAYS][SETS];
    logic [TW-1:0]   tag_d   [WAYS][SETS];
    logic            valid_q [WAYS][SETS];
    logic            valid_d [WAYS][SETS];
    logic [WB-1:0]   rr_q    [SETS];
    logic [WB-1:0]   rr_d    [SETS];

    logic [OB-1:0]   offset;
    logic [IB-1:0]   index;
    logic [TW-1:0]   tag;
    logic            hit;
    logic [WB-1:0]   hit_way;
    logic            set_full;
    logic [WB-1:0]   pick_way;
    logic            found_free;
    logic            beat_err;
    logic            fill_err;
    logic            unused_pc;

    assign offset    = bus.pc[OB+1:2];
    assign index     = bus.pc[OB+IB+1:OB+2];
    assign tag       = bus.pc[31:OB+IB+2];
    assign unused_pc = ^bus.pc[1:0];

    // Lookup and victim choice both read the set addressed by the held pc.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        set_full   = 1'b1;
        found_free = 1'b0;
        pick_way   = rr_q[index];
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][index] && (tag_q[w][index] == tag) && !hit) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
            if (!valid_q[w][index]) begin
                set_full = 1'b0;
                if (!found_free) begin
                    found_free = 1'b1;
                    pick_way   = WB'(w);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        set_full_d   = set_full_q;
        beat_d       = beat_q;
        err_d        = err_q;
        pend_flush_d = pend_flush_q;
        inst_d       = inst_q;
        inst_valid_d = 1'b0;
        inst_fault_d = 1'b0;
        arvalid_d    = arvalid_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        data_d       = data_q;
        tag_d        = tag_q;
        valid_d      = valid_q;
        rr_d         = rr_q;
        beat_err     = (bus.rresp != 2'b00);
        fill_err     = err_q | beat_err;

        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    for (int w = 0; w < WAYS; w++)
                        for (int s = 0; s < SETS; s++)
                            valid_d[w][s] = 1'b0;
                end
                if (bus.inst_require) begin
                    if (hit && !bus.flush) begin
                        inst_d       = data_q[hit_way][index][offset];
                        inst_valid_d = 1'b1;
                        hit_cnt_d    = hit_cnt_q + 32'd1;
                    end else begin
                        // A coincident flush empties the set, so way 0 is the first free way.
                        victim_d   = bus.flush ? '0 : pick_way;
                        set_full_d = bus.flush ? 1'b0 : set_full;
                        arvalid_d  = 1'b1;
                        err_d      = 1'b0;
                        miss_cnt_d = miss_cnt_q + 32'd1;
                        state_d    = AR;
                    end
                end
            end
            AR: begin
                if (bus.flush)
                    pend_flush_d = 1'b1;
                if (bus.arready) begin
                    arvalid_d = 1'b0;
                    beat_d    = '0;
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (bus.flush)
                    pend_flush_d = 1'b1;
                if (bus.rvalid) begin
                    data_d[victim_q][index][beat_q] = bus.rdata;
                    beat_d = beat_q + 1'b1;
                    err_d  = fill_err;
                    if (bus.rlast) begin
                        state_d      = RESP;
                        inst_valid_d = 1'b1;
                        if (fill_err) begin
                            inst_d       = '0;
                            inst_fault_d = 1'b1;
                        end else begin
                            inst_d = (beat_q == offset) ? bus.rdata
                                                        : data_q[victim_q][index][offset];
                            valid_d[victim_q][index] = 1'b1;
                            tag_d[victim_q][index]   = tag;
                            if (set_full_q)
                                rr_d[index] = (rr_q[index] == WB'(WAYS - 1)) ? '0
                                                                              : rr_q[index] + 1'b1;
                        end
                    end
                end
            end
            RESP: begin
                state_d      = IDLE;
                pend_flush_d = 1'b0;
                if (bus.flush || pend_flush_q) begin
                    for (int w = 0; w < WAYS; w++)
                        for (int s = 0; s < SETS; s++)
                            valid_d[w][s] = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            victim_q     <= '0;
            set_full_q   <= 1'b0;
            beat_q       <= '0;
            err_q        <= 1'b0;
            pend_flush_q <= 1'b0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            inst_fault_q <= 1'b0;
            arvalid_q    <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++)
                    valid_q[w][s] <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            set_full_q   <= set_full_d;
            beat_q       <= beat_d;
            err_q        <= err_d;
            pend_flush_q <= pend_flush_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            inst_fault_q <= inst_fault_d;
            arvalid_q    <= arvalid_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            rr_q         <= rr_d;
            valid_q      <= valid_d;
        end
    end

    // Line data and tags are qualified by valid bits, so they need no reset.
    always_ff @(posedge clock) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

    assign bus.inst_valid = inst_valid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_fault = inst_fault_q;
    assign bus.arvalid    = arvalid_q;
    assign bus.araddr     = {bus.pc[31:OB+2], {(OB + 2){1'b0}}};
    assign bus.arlen      = 8'(LINE_WORDS - 1);
    assign bus.arsize     = 3'b010;
    assign bus.arburst    = 2'b01;
    assign bus.rready     = 1'b1;
    assign bus.hit_cnt    = hit_cnt_q;
    assign bus.miss_cnt   = miss_cnt_q;
endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa (WAYS=2, SETS=8, LINE_WORDS=4); the bench plays both
// the IFU and the AXI memory and samples everything on the falling clock edge.
module tb_icache_sa;
    logic clock;
    logic reset;
    int   errors;
    int   checks;
    int   expHit;
    int   expMiss;

    icache_sa_if bus ();

    icache_sa #(.WAYS(2), .SETS(8), .LINE_WORDS(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Hit: response one cycle after the request, with no AR traffic.
    task automatic doHit(input logic [31:0] addr, input logic [31:0] expInst, input string tag);
        bus.inst_require = 1'b1;
        bus.pc           = addr;
        tick();
        expHit++;
        checkOutput({tag, "_valid"}, 32'(bus.inst_valid), 32'd1);
        checkOutput({tag, "_inst"}, bus.inst, expInst);
        checkOutput({tag, "_noar"}, 32'(bus.arvalid), 32'd0);
        checkOutput({tag, "_hitcnt"}, bus.hit_cnt, 32'(expHit));
        bus.inst_require = 1'b0;
        tick();
        checkOutput({tag, "_pulse"}, 32'(bus.inst_valid), 32'd0);
    endtask

    // Miss: memory returns base+beat for each beat; errBeat/flushBeat < 0 disables them.
    task automatic doMiss(input logic [31:0] addr, input logic [31:0] base, input int arDelay,
                          input int errBeat, input int flushBeat, input string tag);
        logic [31:0] expInst;
        logic        expFault;
        expFault = (errBeat >= 0);
        expInst  = expFault ? 32'd0 : base + 32'(addr[3:2]);
        bus.inst_require = 1'b1;
        bus.pc           = addr;
        tick();
        expMiss++;
        checkOutput({tag, "_arvalid"}, 32'(bus.arvalid), 32'd1);
        checkOutput({tag, "_araddr"}, bus.araddr, addr & 32'hFFFF_FFF0);
        checkOutput({tag, "_misscnt"}, bus.miss_cnt, 32'(expMiss));
        for (int i = 1; i < arDelay; i++) begin
            tick();
            checkOutput({tag, "_arhold"}, 32'(bus.arvalid), 32'd1);
        end
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        checkOutput({tag, "_ardrop"}, 32'(bus.arvalid), 32'd0);
        for (int b = 0; b < 4; b++) begin
            bus.rvalid = 1'b1;
            bus.rdata  = base + 32'(b);
            bus.rresp  = (b == errBeat) ? 2'b10 : 2'b00;
            bus.rlast  = (b == 3);
            bus.flush  = (b == flushBeat);
            tick();
            if (b < 3)
                checkOutput({tag, "_early"}, 32'(bus.inst_valid), 32'd0);
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
        bus.flush  = 1'b0;
        checkOutput({tag, "_valid"}, 32'(bus.inst_valid), 32'd1);
        checkOutput({tag, "_inst"}, bus.inst, expInst);
        checkOutput({tag, "_fault"}, 32'(bus.inst_fault), 32'(expFault));
        bus.inst_require = 1'b0;
        tick();
        checkOutput({tag, "_pulse"}, 32'(bus.inst_valid), 32'd0);
        checkOutput({tag, "_faultpulse"}, 32'(bus.inst_fault), 32'd0);
    endtask

    task automatic applyStimulus();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        expHit = 0;
        expMiss = 0;
        reset = 1'b1;
        bus.inst_require = 1'b0;
        bus.pc      = 32'h0;
        bus.flush   = 1'b0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'h0;
        bus.rresp   = 2'b00;
        bus.rlast   = 1'b0;
        tick();
        tick();
        checkOutput("rst_valid", 32'(bus.inst_valid), 32'd0);
        checkOutput("rst_inst", bus.inst, 32'd0);
        checkOutput("rst_fault", 32'(bus.inst_fault), 32'd0);
        checkOutput("rst_arvalid", 32'(bus.arvalid), 32'd0);
        checkOutput("rst_hitcnt", bus.hit_cnt, 32'd0);
        checkOutput("rst_misscnt", bus.miss_cnt, 32'd0);
        checkOutput("const_arlen", 32'(bus.arlen), 32'd3);
        checkOutput("const_arsize", 32'(bus.arsize), 32'd2);
        checkOutput("const_arburst", 32'(bus.arburst), 32'd1);
        checkOutput("const_rready", 32'(bus.rready), 32'd1);
        reset = 1'b0;
        tick();

        $display("[TB] cold miss and hits");
        doMiss(32'h8000_0008, 32'hA0, 3, -1, -1, "cold");
        doHit(32'h8000_0000, 32'hA0, "hit0");
        doHit(32'h8000_000C, 32'hA3, "hit3");

        $display("[TB] conflict misses in set 1");
        doMiss(32'h0000_0010, 32'hB0, 1, -1, -1, "t0");
        doMiss(32'h0000_0090, 32'hC0, 2, -1, -1, "t1");
        doMiss(32'h0000_0110, 32'hD0, 1, -1, -1, "t2");
        doHit(32'h0000_0094, 32'hC1, "t1hit");
        doHit(32'h0000_0118, 32'hD2, "t2hit");
        doMiss(32'h0000_0010, 32'hE0, 1, -1, -1, "t0again");
        doHit(32'h0000_0114, 32'hD1, "t2keep");
        doHit(32'h0000_001C, 32'hE3, "t0hit");
        doMiss(32'h0000_0090, 32'hC8, 1, -1, -1, "t1evicted");

        $display("[TB] flush in idle and during fill");
        applyStimulus();
        doMiss(32'h8000_0000, 32'hF0, 1, -1, -1, "postflush");
        doHit(32'h8000_0004, 32'hF1, "postflushhit");
        doMiss(32'h0000_0204, 32'h40, 2, -1, 1, "flushfill");
        doMiss(32'h0000_0204, 32'h50, 1, -1, -1, "flushrefetch");

        $display("[TB] bus error on beat 2");
        doMiss(32'h0000_0308, 32'h60, 1, 2, -1, "err");
        doMiss(32'h0000_0308, 32'h70, 1, -1, -1, "errrefetch");
        doHit(32'h0000_0300, 32'h70, "errhit");

        $display("[TB] reset during fill");
        bus.inst_require = 1'b1;
        bus.pc = 32'h0000_0400;
        tick();
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.rvalid = 1'b1;
            bus.rdata  = 32'h90 + 32'(b);
            tick();
        end
        bus.rvalid = 1'b0;
        bus.inst_require = 1'b0;
        reset = 1'b1;
        tick();
        checkOutput("midrst_arvalid", 32'(bus.arvalid), 32'd0);
        checkOutput("midrst_valid", 32'(bus.inst_valid), 32'd0);
        checkOutput("midrst_hitcnt", bus.hit_cnt, 32'd0);
        checkOutput("midrst_misscnt", bus.miss_cnt, 32'd0);
        reset = 1'b0;
        expHit = 0;
        expMiss = 0;
        tick();
        checkOutput("postrst_idle", 32'(bus.arvalid), 32'd0);
        doMiss(32'h0000_0300, 32'h80, 1, -1, -1, "postrst");
        doHit(32'h0000_030C, 32'h83, "postrsthit");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
